// File: rtl/lcd_feed_pkg.sv
// lcd_feed_pkg: shared FSM state type and default sizing for lcd_byte_feeder
package lcd_feed_pkg;
  typedef enum logic {IDLE, SHOW} feed_state_t;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_DWELL = 50_000_000;
endpackage

// File: rtl/lcd_feed_fifo.sv
// lcd_feed_fifo: byte FIFO with extra-bit pointers and optional overwrite-oldest-on-full
module lcd_feed_fifo
  import lcd_feed_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, adv;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign dout  = mem[rp[AW-1:0]];
  assign wr    = push && (!full || pop || OVERWRITE);
  // an overwriting push lands on the head slot, so the head must move past it
  assign adv   = (pop && !empty) || (OVERWRITE && push && full && !pop);
  always_ff @(posedge clock) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + {{AW{1'b0}}, wr};
      rp <= rp + {{AW{1'b0}}, adv};
    end
  end
  always_ff @(posedge clock) if (rst && wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/lcd_byte_feeder.sv
// lcd_byte_feeder: queues bus bytes and shows each on hex1/hex0 for DWELL cycles.
// Macro LCD_FEED_DROP_OLDEST_EN: never stall the bus; overwrite oldest byte and count drops.
module lcd_byte_feeder
  import lcd_feed_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DWELL = DEF_DWELL
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       bus_valid,
  input  logic [7:0] bus_data,
  output logic       bus_ready,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic       disp_valid,
  output logic [7:0] drop_cnt
);
  localparam int CW = $clog2(DWELL);
  feed_state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] dout;
  logic full, empty, push, pop, last;
  assign last = cnt == CW'(DWELL - 1);
  assign pop  = !empty && (state == IDLE || last);
  assign push = bus_valid && bus_ready;
`ifdef LCD_FEED_DROP_OLDEST_EN
  localparam bit OVW = 1'b1;
  assign bus_ready = 1'b1;
  always_ff @(posedge clock) begin
    if (!rst) drop_cnt <= '0;
    else if (push && full && !pop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`else
  localparam bit OVW = 1'b0;
  assign bus_ready = !full;
  assign drop_cnt  = '0;
`endif
  lcd_feed_fifo #(.DEPTH(DEPTH), .OVERWRITE(OVW)) u_fifo (
    .clock(clock),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(bus_data),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clock) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      {hex1, hex0} <= 8'h00;
      disp_valid <= 1'b0;
    end else if (pop) begin
      state      <= SHOW;
      cnt        <= '0;
      {hex1, hex0} <= dout;
      disp_valid <= 1'b1;
    end else if (state == SHOW) begin
      state <= last ? IDLE : SHOW;
      cnt   <= last ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: doc/lcd_byte_feeder.md
LCD_BYTE_FEEDER -- requirements
Module: lcd_byte_feeder

Interface
- REQ-001: Parameter DEPTH, default 4; FIFO entries; power of two, 2..16.
- REQ-002: Parameter DWELL, default 50_000_000; clock cycles each byte is shown (1 s at 50 MHz); minimum 2.
- REQ-003: clock, input, 1, single system clock; all logic on its rising edge.
- REQ-004: rst, input, 1, synchronous active-low reset.
- REQ-005: bus_valid, input, 1, bus side offers bus_data this cycle.
- REQ-006: bus_data, input, 8, byte captured from a system-bus write.
- REQ-007: bus_ready, output, 1, block accepts bus_data this cycle.
- REQ-008: hex1, output, 4, upper nibble of the displayed byte, to LCD display stage.
- REQ-009: hex0, output, 4, lower nibble of the displayed byte.
- REQ-010: disp_valid, output, 1, hex1/hex0 hold a received byte.
- REQ-011: drop_cnt, output, 8, count of bytes discarded by overflow; meaningful only with the macro in REQ-030.

Function
- REQ-012: A push occurs on a rising edge where bus_valid=1 and bus_ready=1; bus_data is written at the FIFO tail.
- REQ-013: bus_ready shall be the combinational inverse of FIFO full, without the macro.
- REQ-014: A push while bus_ready=0 shall not alter FIFO contents.
- REQ-015: The FSM shall have two states: IDLE and SHOW.
- REQ-016: In IDLE with the FIFO non-empty, the FSM shall pop the head, register it onto hex1/hex0, set disp_valid=1, clear the dwell counter and enter SHOW, all on the same edge.
- REQ-017: In SHOW, the dwell counter shall increment each cycle.
- REQ-018: When the counter reaches DWELL-1 and the FIFO is non-empty, the FSM shall pop and display the next byte and clear the counter on that edge, remaining in SHOW.
- REQ-019: When the counter reaches DWELL-1 and the FIFO is empty, the FSM shall enter IDLE.
- REQ-020: hex1/hex0 shall keep the last byte indefinitely in IDLE.
- REQ-021: Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE shall appear on hex1/hex0 after edge N+1.
- REQ-022: Each accepted byte shall be displayed for exactly DWELL cycles, unless it is the last byte (REQ-020).
- REQ-023: Bytes shall be displayed in arrival order, with no byte lost or repeated.
- REQ-024: A simultaneous push and pop on a full FIFO shall not occur without the macro, since bus_ready=0 when full; occupancy is otherwise updated by +1, -1 or 0 correctly.
- REQ-025: FIFO pointers shall wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit.
- REQ-026: The dwell counter width shall be ceil(log2(DWELL)); it shall never exceed DWELL-1.

Reset
- REQ-027: While rst=0 at an edge, the following shall hold after that edge: FIFO empty; FSM in IDLE; counter=0; hex1=0; hex0=0; disp_valid=0; drop_cnt=0.
- REQ-028: bus_ready shall be 1 after reset.
- REQ-029: A reset mid-dwell shall discard all queued bytes and the displayed byte; no push shall be taken on a reset edge.

Configuration
- REQ-030: Macro LCD_FEED_DROP_OLDEST_EN.
  - Defined: bus_ready is constantly 1. A push into a full FIFO with no pop that cycle shall overwrite the oldest entry (head advances) and increment drop_cnt, saturating at 255. With a pop in the same cycle, the push is normal and no drop occurs.
  - Undefined: REQ-013 applies and drop_cnt is tied to 0.

Structure
- REQ-031: Package lcd_feed_pkg shall hold the FSM state typedef (IDLE, SHOW) and the default DEPTH and DWELL constants.
- REQ-032: Storage and pointers shall sit in one sub-module, lcd_feed_fifo, exposing push, pop, din, dout, full, empty and an overwrite-on-full option; the FSM and dwell counter shall sit in lcd_byte_feeder.

Verification (DWELL=4, DEPTH=4 unless noted)
- REQ-033: Reset, then push 0x3C at edge N -> hex1=3, hex0=C, disp_valid=1 after edge N+1; values hold after the FSM returns to IDLE.
- REQ-034: Push 0x11, 0x22, 0x33 back-to-back -> each is shown in order for exactly 4 cycles; 0x33 persists afterwards.
- REQ-035: Hold bus_valid=1 with 6 bytes, macro undefined -> bus_ready falls when full; all 6 bytes are displayed in order; drop_cnt=0.
- REQ-036: Same stimulus, macro defined -> bus_ready stays 1; the oldest queued bytes are overwritten; drop_cnt equals the number of overflow pushes; survivors are displayed in order.
- REQ-037: Assert rst=0 during the second cycle of a dwell with 2 bytes queued -> the next cycle shows hex=0, disp_valid=0, FIFO empty and bus_ready=1.
- REQ-038: Push 10 bytes spaced to force pointer wrap at DEPTH=4 -> the display sequence matches the input exactly.
